data_mem_responder: RTL and testbench



---
 rtl/data_mem_pkg.sv | 35 +++
 rtl/mmio_timer.sv | 68 ++++++
 rtl/data_mem_responder.sv | 193 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants for the data memory responder: MMIO register offsets,
// control/status bit positions, register reset values and the address
// region classification used by the decoder.
package data_mem_pkg;

   // Byte offsets of the MMIO registers within the 256-byte page
   localparam logic [7:0] MMIO_GPIO_OUT    = 8'h00;
   localparam logic [7:0] MMIO_GPIO_IN     = 8'h04;
   localparam logic [7:0] MMIO_TIMER_COUNT = 8'h08;
   localparam logic [7:0] MMIO_TIMER_CMP   = 8'h0C;
   localparam logic [7:0] MMIO_TIMER_CTRL  = 8'h10;
   localparam logic [7:0] MMIO_ERR_STATUS  = 8'h14;
   localparam logic [7:0] MMIO_ERR_ADDR    = 8'h18;

   // TIMER_CTRL bit positions
   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_PEND_BIT = 1;

   // ERR_STATUS bit positions
   localparam int ERR_MIS_BIT = 0;
   localparam int ERR_UNM_BIT = 1;

   // Register reset values
   localparam logic [31:0] GPIO_OUT_RST    = 32'h0000_0000;
   localparam logic [31:0] TIMER_COUNT_RST = 32'h0000_0000;
   localparam logic [31:0] TIMER_CMP_RST   = 32'hFFFF_FFFF;

   // Which region the presented byte address falls into
   typedef enum logic [1:0] {
      REGION_UNMAPPED = 2'd0,
      REGION_RAM      = 2'd1,
      REGION_MMIO     = 2'd2
   } region_e;

endpackage

// File: rtl/mmio_timer.sv
// Compare timer for the MMIO page: free-running COUNT with core override,
// CMP match sets a sticky pending bit, irq is pending gated by enable.
module mmio_timer
   import data_mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_count_wr,
   input  logic        i_cmp_wr,
   input  logic        i_ctrl_wr,
   input  logic [31:0] i_wr_data,
   output logic [31:0] o_count,
   output logic [31:0] o_cmp,
   output logic        o_enable,
   output logic        o_pending,
   output logic        o_irq
);

   logic [31:0] count_q, count_d;
   logic [31:0] cmp_q, cmp_d;
   logic        enable_q, enable_d;
   logic        pending_q, pending_d;
   logic        match_set;
   logic        pend_clear;

   // Next-state: core writes beat the increment, and a match beats a clear
   always_comb begin
      count_d    = count_q;
      cmp_d      = cmp_q;
      enable_d   = enable_q;
      match_set  = enable_q && (count_q == cmp_q);
      pend_clear = i_ctrl_wr && i_wr_data[CTRL_PEND_BIT];
      if (i_count_wr) begin
         count_d = i_wr_data;
      end else if (enable_q) begin
         count_d = count_q + 32'd1;
      end
      if (i_cmp_wr) begin
         cmp_d = i_wr_data;
      end
      if (i_ctrl_wr) begin
         enable_d = i_wr_data[CTRL_EN_BIT];
      end
      pending_d = match_set || (pending_q && !pend_clear);
   end

   // Timer state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= TIMER_COUNT_RST;
         cmp_q     <= TIMER_CMP_RST;
         enable_q  <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         cmp_q     <= cmp_d;
         enable_q  <= enable_d;
         pending_q <= pending_d;
      end
   end

   assign o_count   = count_q;
   assign o_cmp     = cmp_q;
   assign o_enable  = enable_q;
   assign o_pending = pending_q;
   assign o_irq     = pending_q && enable_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the core's data memory interface: word RAM plus an MMIO
// page (GPIO, compare timer, bus-error capture). Read data is registered,
// so every address presented returns its data one cycle later.
module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int                           DATA_WIDTH_P      = 32,
   parameter int                           DATA_ADDR_WIDTH_P = 32,
   parameter int                           RAM_DEPTH_P       = 256,
   parameter logic [DATA_ADDR_WIDTH_P-1:0] MMIO_BASE_P       = 32'hFFFF0000,
   parameter string                        INIT_FILE_P       = ""
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_mem_wr_en,
   input  logic [DATA_ADDR_WIDTH_P-1:0] i_mem_addr,
   input  logic [DATA_WIDTH_P-1:0]      i_mem_wr_data,
   output logic [DATA_WIDTH_P-1:0]      o_mem_rd_data,
   input  logic [31:0]                  i_gpio,
   output logic [31:0]                  o_gpio,
   output logic                         o_timer_irq,
   output logic                         o_bus_error
);

   localparam int RAM_AW = $clog2(RAM_DEPTH_P);
   localparam logic [DATA_ADDR_WIDTH_P-1:0] RAM_LIMIT = DATA_ADDR_WIDTH_P'(RAM_DEPTH_P * 4);

   logic [DATA_WIDTH_P-1:0]      ram_mem [RAM_DEPTH_P];

   region_e                      region;
   logic                         misaligned;
   logic [7:0]                   offset;
   logic [RAM_AW-1:0]            ram_idx;

   logic                         ram_we;
   logic                         gpio_out_we;
   logic                         count_wr;
   logic                         cmp_wr;
   logic                         ctrl_wr;
   logic                         status_wr;
   logic                         err_mis;
   logic                         err_unm;

   logic [DATA_WIDTH_P-1:0]      rd_data_q, rd_data_d;
   logic [31:0]                  gpio_out_q, gpio_out_d;
   logic [31:0]                  gpio_meta_q, gpio_meta_d;
   logic [31:0]                  gpio_sync_q, gpio_sync_d;
   logic [1:0]                   err_status_q, err_status_d;
   logic [DATA_ADDR_WIDTH_P-1:0] err_addr_q, err_addr_d;

   logic [31:0]                  timer_count;
   logic [31:0]                  timer_cmp;
   logic                         timer_enable;
   logic                         timer_pending;
   logic [1:0]                   ctrl_bits;

   // Address decode into RAM / MMIO / unmapped
   always_comb begin
      region = REGION_UNMAPPED;
      if (i_mem_addr < RAM_LIMIT) begin
         region = REGION_RAM;
      end else if (i_mem_addr[DATA_ADDR_WIDTH_P-1:8] == MMIO_BASE_P[DATA_ADDR_WIDTH_P-1:8]) begin
         region = REGION_MMIO;
      end
   end

   assign misaligned = (i_mem_addr[1:0] != 2'b00);
   assign offset     = i_mem_addr[7:0];
   assign ram_idx    = i_mem_addr[2 +: RAM_AW];

   // Write steering; reset blocks every write, misalignment takes precedence
   always_comb begin
      ram_we      = 1'b0;
      gpio_out_we = 1'b0;
      count_wr    = 1'b0;
      cmp_wr      = 1'b0;
      ctrl_wr     = 1'b0;
      status_wr   = 1'b0;
      err_mis     = 1'b0;
      err_unm     = 1'b0;
      if (i_mem_wr_en && !reset) begin
         if (misaligned) begin
            err_mis = 1'b1;
         end else if (region == REGION_RAM) begin
            ram_we = 1'b1;
         end else if (region == REGION_MMIO) begin
            case (offset)
               MMIO_GPIO_OUT:    gpio_out_we = 1'b1;
               MMIO_TIMER_COUNT: count_wr    = 1'b1;
               MMIO_TIMER_CMP:   cmp_wr      = 1'b1;
               MMIO_TIMER_CTRL:  ctrl_wr     = 1'b1;
               MMIO_ERR_STATUS:  status_wr   = 1'b1;
               default:          err_unm     = 1'b1;
            endcase
         end else begin
            err_unm = 1'b1;
         end
      end
   end

   assign ctrl_bits[CTRL_EN_BIT]   = timer_enable;
   assign ctrl_bits[CTRL_PEND_BIT] = timer_pending;

   // Read mux from the current address; RAM word is the pre-write value
   always_comb begin
      rd_data_d = '0;
      if (!misaligned) begin
         if (region == REGION_RAM) begin
            rd_data_d = ram_mem[ram_idx];
         end else if (region == REGION_MMIO) begin
            case (offset)
               MMIO_GPIO_OUT:    rd_data_d = DATA_WIDTH_P'(gpio_out_q);
               MMIO_GPIO_IN:     rd_data_d = DATA_WIDTH_P'(gpio_sync_q);
               MMIO_TIMER_COUNT: rd_data_d = DATA_WIDTH_P'(timer_count);
               MMIO_TIMER_CMP:   rd_data_d = DATA_WIDTH_P'(timer_cmp);
               MMIO_TIMER_CTRL:  rd_data_d = DATA_WIDTH_P'(ctrl_bits);
               MMIO_ERR_STATUS:  rd_data_d = DATA_WIDTH_P'(err_status_q);
               MMIO_ERR_ADDR:    rd_data_d = DATA_WIDTH_P'(err_addr_q);
               default:          rd_data_d = '0;
            endcase
         end
      end
   end

   // GPIO, synchroniser and error-capture next state; new errors beat clears
   always_comb begin
      gpio_out_d   = gpio_out_q;
      gpio_meta_d  = i_gpio;
      gpio_sync_d  = gpio_meta_q;
      err_status_d = err_status_q;
      err_addr_d   = err_addr_q;
      if (gpio_out_we) begin
         gpio_out_d = i_mem_wr_data[31:0];
      end
      if (status_wr) begin
         err_status_d = err_status_q & ~i_mem_wr_data[1:0];
      end
      if (err_mis) begin
         err_status_d[ERR_MIS_BIT] = 1'b1;
      end
      if (err_unm) begin
         err_status_d[ERR_UNM_BIT] = 1'b1;
      end
      if (err_mis || err_unm) begin
         err_addr_d = i_mem_addr;
      end
   end

   // Register page, synchroniser and read-data registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q    <= '0;
         gpio_out_q   <= GPIO_OUT_RST;
         gpio_meta_q  <= '0;
         gpio_sync_q  <= '0;
         err_status_q <= '0;
         err_addr_q   <= '0;
      end else begin
         rd_data_q    <= rd_data_d;
         gpio_out_q   <= gpio_out_d;
         gpio_meta_q  <= gpio_meta_d;
         gpio_sync_q  <= gpio_sync_d;
         err_status_q <= err_status_d;
         err_addr_q   <= err_addr_d;
      end
   end

   // RAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_mem[ram_idx] <= i_mem_wr_data;
      end
   end

   mmio_timer u_timer (
      .clk       (clk),
      .reset     (reset),
      .i_count_wr(count_wr),
      .i_cmp_wr  (cmp_wr),
      .i_ctrl_wr (ctrl_wr),
      .i_wr_data (i_mem_wr_data[31:0]),
      .o_count   (timer_count),
      .o_cmp     (timer_cmp),
      .o_enable  (timer_enable),
      .o_pending (timer_pending),
      .o_irq     (o_timer_irq)
   );

   assign o_mem_rd_data = rd_data_q;
   assign o_gpio        = gpio_out_q;
   assign o_bus_error   = |err_status_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a vector table for RAM/MMIO/error
// behaviour, then hand-written sequences for GPIO sync, timer and reset.
module tb_data_mem_responder;

   localparam logic [31:0] A_GPIO_OUT = 32'hFFFF_0000;
   localparam logic [31:0] A_GPIO_IN  = 32'hFFFF_0004;
   localparam logic [31:0] A_COUNT    = 32'hFFFF_0008;
   localparam logic [31:0] A_CMP      = 32'hFFFF_000C;
   localparam logic [31:0] A_CTRL     = 32'hFFFF_0010;
   localparam logic [31:0] A_STATUS   = 32'hFFFF_0014;
   localparam logic [31:0] A_ERRADDR  = 32'hFFFF_0018;

   logic        clk;
   logic        reset;
   logic        i_mem_wr_en;
   logic [31:0] i_mem_addr;
   logic [31:0] i_mem_wr_data;
   logic [31:0] o_mem_rd_data;
   logic [31:0] i_gpio;
   logic [31:0] o_gpio;
   logic        o_timer_irq;
   logic        o_bus_error;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic [31:0] exp_gpio;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   data_mem_responder dut (
      .clk          (clk),
      .reset        (reset),
      .i_mem_wr_en  (i_mem_wr_en),
      .i_mem_addr   (i_mem_addr),
      .i_mem_wr_data(i_mem_wr_data),
      .o_mem_rd_data(o_mem_rd_data),
      .i_gpio       (i_gpio),
      .o_gpio       (o_gpio),
      .o_timer_irq  (o_timer_irq),
      .o_bus_error  (o_bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one bus cycle and return 1 time unit after the capturing edge
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data);
      i_mem_wr_en   = wr;
      i_mem_addr    = addr;
      i_mem_wr_data = data;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   initial begin
      reset         = 1'b1;
      i_mem_wr_en   = 1'b0;
      i_mem_addr    = 32'h0;
      i_mem_wr_data = 32'h0;
      i_gpio        = 32'h0;

      // wr, addr, wdata, chk_rd, exp_rd, exp_gpio, exp_err
      vecs.push_back('{1'b1, 32'h10,     32'hDEAD_BEEF, 1'b0, 32'h0,          32'h0,  1'b0});
      vecs.push_back('{1'b0, 32'h10,     32'h0,         1'b1, 32'hDEAD_BEEF,  32'h0,  1'b0});
      vecs.push_back('{1'b1, 32'h10,     32'h1,         1'b1, 32'hDEAD_BEEF,  32'h0,  1'b0});
      vecs.push_back('{1'b0, 32'h10,     32'h0,         1'b1, 32'h1,          32'h0,  1'b0});
      vecs.push_back('{1'b1, 32'h10,     32'hDEAD_BEEF, 1'b1, 32'h1,          32'h0,  1'b0});
      vecs.push_back('{1'b1, 32'h13,     32'h55,        1'b1, 32'h0,          32'h0,  1'b1});
      vecs.push_back('{1'b0, 32'h10,     32'h0,         1'b1, 32'hDEAD_BEEF,  32'h0,  1'b1});
      vecs.push_back('{1'b0, A_STATUS,   32'h0,         1'b1, 32'h1,          32'h0,  1'b1});
      vecs.push_back('{1'b0, A_ERRADDR,  32'h0,         1'b1, 32'h13,         32'h0,  1'b1});
      vecs.push_back('{1'b1, A_STATUS,   32'h1,         1'b1, 32'h1,          32'h0,  1'b0});
      vecs.push_back('{1'b0, A_STATUS,   32'h0,         1'b1, 32'h0,          32'h0,  1'b0});
      vecs.push_back('{1'b1, 32'h1000,   32'h7,         1'b1, 32'h0,          32'h0,  1'b1});
      vecs.push_back('{1'b0, A_STATUS,   32'h0,         1'b1, 32'h2,          32'h0,  1'b1});
      vecs.push_back('{1'b0, A_ERRADDR,  32'h0,         1'b1, 32'h1000,       32'h0,  1'b1});
      vecs.push_back('{1'b1, A_GPIO_IN,  32'h9,         1'b1, 32'h0,          32'h0,  1'b1});
      vecs.push_back('{1'b0, A_ERRADDR,  32'h0,         1'b1, A_GPIO_IN,      32'h0,  1'b1});
      vecs.push_back('{1'b1, A_STATUS,   32'h2,         1'b1, 32'h2,          32'h0,  1'b0});
      vecs.push_back('{1'b1, A_GPIO_OUT, 32'h3C,        1'b1, 32'h0,          32'h3C, 1'b0});
      vecs.push_back('{1'b0, A_GPIO_OUT, 32'h0,         1'b1, 32'h3C,         32'h3C, 1'b0});
      vecs.push_back('{1'b0, 32'hFFFF_0020, 32'h0,      1'b1, 32'h0,          32'h3C, 1'b0});
      vecs.push_back('{1'b0, A_CMP,      32'h0,         1'b1, 32'hFFFF_FFFF,  32'h3C, 1'b0});
      vecs.push_back('{1'b0, A_COUNT,    32'h0,         1'b1, 32'h0,          32'h3C, 1'b0});
      vecs.push_back('{1'b0, A_CTRL,     32'h0,         1'b1, 32'h0,          32'h3C, 1'b0});
      vecs.push_back('{1'b0, 32'h2000,   32'h0,         1'b1, 32'h0,          32'h3C, 1'b0});

      // Reset state
      @(posedge clk);
      #1;
      checkOutput("rst_rd_data", o_mem_rd_data, 32'h0);
      checkOutput("rst_gpio", o_gpio, 32'h0);
      checkOutput("rst_irq", {31'b0, o_timer_irq}, 32'h0);
      checkOutput("rst_bus_err", {31'b0, o_bus_error}, 32'h0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #2;

      // Table of single-cycle accesses
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         if (vecs[i].chk_rd) begin
            checkOutput($sformatf("vec%0d_rd", i), o_mem_rd_data, vecs[i].exp_rd);
         end
         checkOutput($sformatf("vec%0d_gpio", i), o_gpio, vecs[i].exp_gpio);
         checkOutput($sformatf("vec%0d_bus_err", i), {31'b0, o_bus_error}, {31'b0, vecs[i].exp_err});
      end

      // GPIO input synchroniser latency
      applyStimulus(1'b0, A_GPIO_IN, 32'h0);
      i_gpio = 32'hA5;
      applyStimulus(1'b0, A_GPIO_IN, 32'h0);
      checkOutput("gpio_in_c1", o_mem_rd_data, 32'h0);
      applyStimulus(1'b0, A_GPIO_IN, 32'h0);
      checkOutput("gpio_in_c2", o_mem_rd_data, 32'h0);
      applyStimulus(1'b0, A_GPIO_IN, 32'h0);
      checkOutput("gpio_in_c3", o_mem_rd_data, 32'hA5);

      // Timer compare: irq six edges after enable
      applyStimulus(1'b1, A_CMP, 32'd5);
      applyStimulus(1'b1, A_COUNT, 32'd0);
      applyStimulus(1'b1, A_CTRL, 32'h1);
      checkOutput("tmr_irq_e0", {31'b0, o_timer_irq}, 32'h0);
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1'b0, A_CTRL, 32'h0);
         checkOutput($sformatf("tmr_irq_e%0d", k), {31'b0, o_timer_irq}, 32'h0);
      end
      applyStimulus(1'b0, A_CTRL, 32'h0);
      checkOutput("tmr_irq_e6", {31'b0, o_timer_irq}, 32'h1);
      applyStimulus(1'b0, A_CTRL, 32'h0);
      checkOutput("tmr_ctrl_rd", o_mem_rd_data, 32'h3);
      applyStimulus(1'b1, A_CTRL, 32'h3);
      checkOutput("tmr_irq_cleared", {31'b0, o_timer_irq}, 32'h0);

      // Match and clear in the same cycle: set wins
      applyStimulus(1'b1, A_CMP, 32'h22);
      applyStimulus(1'b1, A_COUNT, 32'h20);
      applyStimulus(1'b0, A_COUNT, 32'h0);
      applyStimulus(1'b0, A_COUNT, 32'h0);
      applyStimulus(1'b1, A_CTRL, 32'h3);
      checkOutput("tmr_set_wins", {31'b0, o_timer_irq}, 32'h1);
      applyStimulus(1'b1, A_CTRL, 32'h3);
      checkOutput("tmr_clear2", {31'b0, o_timer_irq}, 32'h0);

      // Disable freezes COUNT
      applyStimulus(1'b1, A_CTRL, 32'h0);
      applyStimulus(1'b0, A_COUNT, 32'h0);
      checkOutput("tmr_frozen_a", o_mem_rd_data, 32'h25);
      applyStimulus(1'b0, A_COUNT, 32'h0);
      applyStimulus(1'b0, A_COUNT, 32'h0);
      applyStimulus(1'b0, A_COUNT, 32'h0);
      checkOutput("tmr_frozen_b", o_mem_rd_data, 32'h25);

      // COUNT wraps to zero
      applyStimulus(1'b1, A_COUNT, 32'hFFFF_FFFF);
      applyStimulus(1'b1, A_CTRL, 32'h1);
      applyStimulus(1'b0, A_COUNT, 32'h0);
      checkOutput("tmr_wrap_pre", o_mem_rd_data, 32'hFFFF_FFFF);
      applyStimulus(1'b0, A_COUNT, 32'h0);
      checkOutput("tmr_wrap_zero", o_mem_rd_data, 32'h0);
      applyStimulus(1'b1, A_CTRL, 32'h0);

      // Pending survives disable, irq masked then restored
      applyStimulus(1'b1, A_CMP, 32'd3);
      applyStimulus(1'b1, A_COUNT, 32'd0);
      applyStimulus(1'b1, A_CTRL, 32'h1);
      for (int k = 0; k < 20 && !o_timer_irq; k++) begin
         applyStimulus(1'b0, A_CTRL, 32'h0);
      end
      checkOutput("irq_wait", {31'b0, o_timer_irq}, 32'h1);
      applyStimulus(1'b1, A_CTRL, 32'h0);
      checkOutput("irq_masked", {31'b0, o_timer_irq}, 32'h0);
      applyStimulus(1'b0, A_CTRL, 32'h0);
      checkOutput("pending_kept", o_mem_rd_data, 32'h2);
      applyStimulus(1'b1, A_CTRL, 32'h1);
      checkOutput("irq_unmasked", {31'b0, o_timer_irq}, 32'h1);
      applyStimulus(1'b0, 32'h10, 32'h0);
      checkOutput("pre_rst_rd", o_mem_rd_data, 32'hDEAD_BEEF);
      checkOutput("pre_rst_gpio", o_gpio, 32'h3C);

      // Asynchronous reset mid-operation
      #3;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_gpio", o_gpio, 32'h0);
      checkOutput("async_rst_irq", {31'b0, o_timer_irq}, 32'h0);
      checkOutput("async_rst_rd", o_mem_rd_data, 32'h0);
      checkOutput("async_rst_bus_err", {31'b0, o_bus_error}, 32'h0);
      i_mem_wr_en   = 1'b1;
      i_mem_addr    = 32'h10;
      i_mem_wr_data = 32'h1234_5678;
      @(posedge clk);
      #1;
      i_mem_addr    = A_GPIO_OUT;
      i_mem_wr_data = 32'hFF;
      @(posedge clk);
      #1;
      checkOutput("rst_wr_blocked_gpio", o_gpio, 32'h0);
      i_mem_wr_en = 1'b0;
      i_mem_addr  = 32'h10;
      #2;
      reset = 1'b0;
      applyStimulus(1'b0, 32'h10, 32'h0);
      checkOutput("ram_after_rst", o_mem_rd_data, 32'hDEAD_BEEF);
      applyStimulus(1'b0, A_GPIO_OUT, 32'h0);
      checkOutput("gpio_out_after_rst", o_mem_rd_data, 32'h0);
      applyStimulus(1'b0, A_CMP, 32'h0);
      checkOutput("cmp_after_rst", o_mem_rd_data, 32'hFFFF_FFFF);
      applyStimulus(1'b1, A_GPIO_OUT, 32'h5A);
      checkOutput("first_wr_after_rst", o_gpio, 32'h5A);
      applyStimulus(1'b0, 32'h10, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
